axilite4_demux: RTL and testbench



---
 rtl/axilite4_pkg.sv | 23 ++
 rtl/axilite4_demux_if.sv | 40 ++++
 rtl/axilite4_addr_decoder.sv | 25 ++
 rtl/axilite4_demux.sv | 189 ++++++++++++++++++
 tb/tb_axilite4_demux.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axilite4_pkg.sv
// Shared types for the AXI Lite 4 address demux.
// This file holds the channel FSM states, the slave select encoding and the
// default decode-error response code.
package axilite4_pkg;

    // Channel FSM states. The read and write FSMs share this encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Decoded target of a transaction.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_S1   = 2'd1,
        SEL_S2   = 2'd2
    } sel_t;

    // Write response message returned for an unmapped write.
    localparam logic [31:0] DECERR_DEFAULT = 32'h0000_0003;

endpackage

// File: rtl/axilite4_demux_if.sv
// One AXI Lite 4 port with five channels.
// The master modport is the side that issues requests.
//
// Handshake rule for every channel: a beat transfers on a cycle where valid
// and ready are both high. The source holds valid and the payload stable
// until that beat. Ready may depend combinationally on valid.
interface axilite4_demux_if;
    logic [31:0]  readAddr_addr;
    logic         readAddr_valid;
    logic         readAddr_ready;
    logic [127:0] readData_data;
    logic         readData_valid;
    logic         readData_ready;
    logic [31:0]  writeAddr_addr;
    logic         writeAddr_valid;
    logic         writeAddr_ready;
    logic [127:0] writeData_data;
    logic [15:0]  writeData_strb;
    logic         writeData_valid;
    logic         writeData_ready;
    logic [31:0]  writeResp_msg;
    logic         writeResp_valid;
    logic         writeResp_ready;

    modport master (
        output readAddr_addr, readAddr_valid, input readAddr_ready,
        input readData_data, readData_valid, output readData_ready,
        output writeAddr_addr, writeAddr_valid, input writeAddr_ready,
        output writeData_data, writeData_strb, writeData_valid, input writeData_ready,
        input writeResp_msg, writeResp_valid, output writeResp_ready
    );

    modport slave (
        input readAddr_addr, readAddr_valid, output readAddr_ready,
        output readData_data, readData_valid, input readData_ready,
        input writeAddr_addr, writeAddr_valid, output writeAddr_ready,
        input writeData_data, writeData_strb, writeData_valid, output writeData_ready,
        output writeResp_msg, writeResp_valid, input writeResp_ready
    );
endinterface

// File: rtl/axilite4_addr_decoder.sv
// Combinational address decoder for two masked regions.
// When the regions overlap, slave 1 takes priority.
module axilite4_addr_decoder
    import axilite4_pkg::*;
#(
    parameter logic [31:0] SLAVE_1_BASE = 32'h0000_0000,
    parameter logic [31:0] SLAVE_1_MASK = 32'hFFFF_0000,
    parameter logic [31:0] SLAVE_2_BASE = 32'h0001_0000,
    parameter logic [31:0] SLAVE_2_MASK = 32'hFFFF_0000
) (
    input  logic [31:0] addr,
    output sel_t        sel
);

    // Priority compare: slave 1 first, then slave 2, otherwise unmapped.
    always_comb begin
        sel = SEL_NONE;
        if ((addr & SLAVE_1_MASK) == SLAVE_1_BASE) begin
            sel = SEL_S1;
        end else if ((addr & SLAVE_2_MASK) == SLAVE_2_BASE) begin
            sel = SEL_S2;
        end
    end

endmodule

// File: rtl/axilite4_demux.sv
// AXI Lite 4 one-to-two demux. Requests are routed by address range.
// The read and write channels each have their own FSM, and the two FSMs are
// independent. An unmapped address gets a local decode-error response, so
// the master never waits on a slave that does not exist.
module axilite4_demux
    import axilite4_pkg::*;
#(
    parameter logic [31:0]  SLAVE_1_BASE = 32'h0000_0000,
    parameter logic [31:0]  SLAVE_1_MASK = 32'hFFFF_0000,
    parameter logic [31:0]  SLAVE_2_BASE = 32'h0001_0000,
    parameter logic [31:0]  SLAVE_2_MASK = 32'hFFFF_0000,
    parameter logic [127:0] DECERR_DATA  = 128'h0,
    parameter logic [31:0]  DECERR_MSG   = DECERR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    axilite4_demux_if.slave   master,
    axilite4_demux_if.master  slave_1,
    axilite4_demux_if.master  slave_2,
    output logic [1:0]        readState,
    output logic [1:0]        writeState
);

    state_t rstate, wstate;
    sel_t   rsel, wsel;
    sel_t   rselDec, wselDec;

    assign readState  = rstate;
    assign writeState = wstate;

    axilite4_addr_decoder #(
        .SLAVE_1_BASE(SLAVE_1_BASE), .SLAVE_1_MASK(SLAVE_1_MASK),
        .SLAVE_2_BASE(SLAVE_2_BASE), .SLAVE_2_MASK(SLAVE_2_MASK)
    ) u_readDec (.addr(master.readAddr_addr), .sel(rselDec));

    axilite4_addr_decoder #(
        .SLAVE_1_BASE(SLAVE_1_BASE), .SLAVE_1_MASK(SLAVE_1_MASK),
        .SLAVE_2_BASE(SLAVE_2_BASE), .SLAVE_2_MASK(SLAVE_2_MASK)
    ) u_writeDec (.addr(master.writeAddr_addr), .sel(wselDec));

    // Read FSM: latch the target in IDLE, then step through REQ and RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate <= IDLE;
            rsel   <= SEL_NONE;
        end else begin
            case (rstate)
                IDLE: if (master.readAddr_valid) begin
                    rsel   <= rselDec;
                    rstate <= REQ;
                end
                REQ:  if (master.readAddr_valid && master.readAddr_ready) rstate <= RESP;
                RESP: if (master.readData_valid && master.readData_ready) rstate <= IDLE;
                default: rstate <= IDLE;
            endcase
        end
    end

    // Read routing: the selected slave is passed through live, and every
    // other port is held at zero.
    always_comb begin
        master.readAddr_ready  = 1'b0;
        master.readData_data   = '0;
        master.readData_valid  = 1'b0;
        slave_1.readAddr_addr  = '0;
        slave_1.readAddr_valid = 1'b0;
        slave_1.readData_ready = 1'b0;
        slave_2.readAddr_addr  = '0;
        slave_2.readAddr_valid = 1'b0;
        slave_2.readData_ready = 1'b0;
        case (rstate)
            REQ: case (rsel)
                SEL_S1: begin
                    slave_1.readAddr_addr  = master.readAddr_addr;
                    slave_1.readAddr_valid = master.readAddr_valid;
                    master.readAddr_ready  = slave_1.readAddr_ready;
                end
                SEL_S2: begin
                    slave_2.readAddr_addr  = master.readAddr_addr;
                    slave_2.readAddr_valid = master.readAddr_valid;
                    master.readAddr_ready  = slave_2.readAddr_ready;
                end
                default: master.readAddr_ready = 1'b1;
            endcase
            RESP: case (rsel)
                SEL_S1: begin
                    master.readData_data   = slave_1.readData_data;
                    master.readData_valid  = slave_1.readData_valid;
                    slave_1.readData_ready = master.readData_ready;
                end
                SEL_S2: begin
                    master.readData_data   = slave_2.readData_data;
                    master.readData_valid  = slave_2.readData_valid;
                    slave_2.readData_ready = master.readData_ready;
                end
                default: begin
                    master.readData_data  = DECERR_DATA;
                    master.readData_valid = 1'b1;
                end
            endcase
            default: ;
        endcase
    end

    // Write FSM: leave IDLE only when both address and data are offered.
    // Address and data are then accepted together in REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate <= IDLE;
            wsel   <= SEL_NONE;
        end else begin
            case (wstate)
                IDLE: if (master.writeAddr_valid && master.writeData_valid) begin
                    wsel   <= wselDec;
                    wstate <= REQ;
                end
                REQ: if (master.writeAddr_valid && master.writeData_valid &&
                         master.writeAddr_ready) wstate <= RESP;
                RESP: if (master.writeResp_valid && master.writeResp_ready) wstate <= IDLE;
                default: wstate <= IDLE;
            endcase
        end
    end

    // Write routing: both master readys are the AND of the slave readys,
    // which keeps the address and data handshakes joint.
    always_comb begin
        master.writeAddr_ready  = 1'b0;
        master.writeData_ready  = 1'b0;
        master.writeResp_msg    = '0;
        master.writeResp_valid  = 1'b0;
        slave_1.writeAddr_addr  = '0;
        slave_1.writeAddr_valid = 1'b0;
        slave_1.writeData_data  = '0;
        slave_1.writeData_strb  = '0;
        slave_1.writeData_valid = 1'b0;
        slave_1.writeResp_ready = 1'b0;
        slave_2.writeAddr_addr  = '0;
        slave_2.writeAddr_valid = 1'b0;
        slave_2.writeData_data  = '0;
        slave_2.writeData_strb  = '0;
        slave_2.writeData_valid = 1'b0;
        slave_2.writeResp_ready = 1'b0;
        case (wstate)
            REQ: case (wsel)
                SEL_S1: begin
                    slave_1.writeAddr_addr  = master.writeAddr_addr;
                    slave_1.writeAddr_valid = master.writeAddr_valid;
                    slave_1.writeData_data  = master.writeData_data;
                    slave_1.writeData_strb  = master.writeData_strb;
                    slave_1.writeData_valid = master.writeData_valid;
                    master.writeAddr_ready  = slave_1.writeAddr_ready & slave_1.writeData_ready;
                    master.writeData_ready  = slave_1.writeAddr_ready & slave_1.writeData_ready;
                end
                SEL_S2: begin
                    slave_2.writeAddr_addr  = master.writeAddr_addr;
                    slave_2.writeAddr_valid = master.writeAddr_valid;
                    slave_2.writeData_data  = master.writeData_data;
                    slave_2.writeData_strb  = master.writeData_strb;
                    slave_2.writeData_valid = master.writeData_valid;
                    master.writeAddr_ready  = slave_2.writeAddr_ready & slave_2.writeData_ready;
                    master.writeData_ready  = slave_2.writeAddr_ready & slave_2.writeData_ready;
                end
                default: begin
                    master.writeAddr_ready = master.writeAddr_valid & master.writeData_valid;
                    master.writeData_ready = master.writeAddr_valid & master.writeData_valid;
                end
            endcase
            RESP: case (wsel)
                SEL_S1: begin
                    master.writeResp_msg    = slave_1.writeResp_msg;
                    master.writeResp_valid  = slave_1.writeResp_valid;
                    slave_1.writeResp_ready = master.writeResp_ready;
                end
                SEL_S2: begin
                    master.writeResp_msg    = slave_2.writeResp_msg;
                    master.writeResp_valid  = slave_2.writeResp_valid;
                    slave_2.writeResp_ready = master.writeResp_ready;
                end
                default: begin
                    master.writeResp_msg   = DECERR_MSG;
                    master.writeResp_valid = 1'b1;
                end
            endcase
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axilite4_demux.sv
// Directed testbench for axilite4_demux. The bench models both slaves and
// the master with plain driver code and checks routing, decode errors,
// backpressure and reset abort.
module tb_axilite4_demux;
    import axilite4_pkg::*;

    logic       clk;
    logic       rst;
    logic [1:0] readState, writeState;
    int         checks;
    int         errors;

    axilite4_demux_if mIf();
    axilite4_demux_if s1If();
    axilite4_demux_if s2If();

    axilite4_demux dut (
        .clk(clk), .rst(rst),
        .master(mIf), .slave_1(s1If), .slave_2(s2If),
        .readState(readState), .writeState(writeState)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock. Inputs are driven and outputs are sampled 1 ns
    // after the rising edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        mIf.readAddr_addr = '0;   mIf.readAddr_valid = 0;  mIf.readData_ready = 0;
        mIf.writeAddr_addr = '0;  mIf.writeAddr_valid = 0;
        mIf.writeData_data = '0;  mIf.writeData_strb = '0; mIf.writeData_valid = 0;
        mIf.writeResp_ready = 0;
        s1If.readAddr_ready = 0;  s1If.readData_data = '0; s1If.readData_valid = 0;
        s1If.writeAddr_ready = 0; s1If.writeData_ready = 0;
        s1If.writeResp_msg = '0;  s1If.writeResp_valid = 0;
        s2If.readAddr_ready = 0;  s2If.readData_data = '0; s2If.readData_valid = 0;
        s2If.writeAddr_ready = 0; s2If.writeData_ready = 0;
        s2If.writeResp_msg = '0;  s2If.writeResp_valid = 0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        step(); step();
        checks++; if (readState !== 2'd0) begin errors++; $display("FAIL reset_rstate got %0d exp 0", readState); end
        checks++; if (writeState !== 2'd0) begin errors++; $display("FAIL reset_wstate got %0d exp 0", writeState); end
        checks++; if (mIf.readAddr_ready !== 1'b0) begin errors++; $display("FAIL reset_arready got %b exp 0", mIf.readAddr_ready); end
        checks++; if (mIf.readData_valid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", mIf.readData_valid); end
        checks++; if (mIf.writeResp_valid !== 1'b0) begin errors++; $display("FAIL reset_bvalid got %b exp 0", mIf.writeResp_valid); end
        checks++; if (s1If.readAddr_valid !== 1'b0) begin errors++; $display("FAIL reset_s1_arvalid got %b exp 0", s1If.readAddr_valid); end
        checks++; if (s2If.writeAddr_valid !== 1'b0) begin errors++; $display("FAIL reset_s2_awvalid got %b exp 0", s2If.writeAddr_valid); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_read_s1;
        mIf.readAddr_addr = 32'h0000_0040; mIf.readAddr_valid = 1; #1;
        checks++; if (s1If.readAddr_valid !== 1'b0) begin errors++; $display("FAIL rd1_idle_s1valid got %b exp 0", s1If.readAddr_valid); end
        step(); // IDLE -> REQ
        checks++; if (s1If.readAddr_valid !== 1'b1) begin errors++; $display("FAIL rd1_s1valid got %b exp 1", s1If.readAddr_valid); end
        checks++; if (s1If.readAddr_addr !== 32'h0000_0040) begin errors++; $display("FAIL rd1_s1addr got %h exp 00000040", s1If.readAddr_addr); end
        checks++; if (s2If.readAddr_valid !== 1'b0) begin errors++; $display("FAIL rd1_s2valid got %b exp 0", s2If.readAddr_valid); end
        checks++; if (mIf.readAddr_ready !== 1'b0) begin errors++; $display("FAIL rd1_arready_low got %b exp 0", mIf.readAddr_ready); end
        s1If.readAddr_ready = 1; #1;
        checks++; if (mIf.readAddr_ready !== 1'b1) begin errors++; $display("FAIL rd1_arready_pass got %b exp 1", mIf.readAddr_ready); end
        step(); // REQ -> RESP
        mIf.readAddr_valid = 0; s1If.readAddr_ready = 0; mIf.readData_ready = 1;
        repeat (2) begin
            #1;
            checks++; if (mIf.readData_valid !== 1'b0) begin errors++; $display("FAIL rd1_wait_rvalid got %b exp 0", mIf.readData_valid); end
            checks++; if (readState !== 2'd2) begin errors++; $display("FAIL rd1_wait_state got %0d exp 2", readState); end
            step();
        end
        s1If.readData_valid = 1; s1If.readData_data = {4{32'hA5A5_A5A5}}; #1;
        checks++; if (mIf.readData_data !== {4{32'hA5A5_A5A5}}) begin errors++; $display("FAIL rd1_rdata got %h exp a5..", mIf.readData_data); end
        checks++; if (mIf.readData_valid !== 1'b1) begin errors++; $display("FAIL rd1_rvalid got %b exp 1", mIf.readData_valid); end
        checks++; if (s1If.readData_ready !== 1'b1) begin errors++; $display("FAIL rd1_s1rready got %b exp 1", s1If.readData_ready); end
        step(); // RESP -> IDLE
        clear_inputs(); #1;
        checks++; if (readState !== 2'd0) begin errors++; $display("FAIL rd1_done_state got %0d exp 0", readState); end
        step();
    endtask

    task automatic test_write_s2;
        mIf.writeAddr_addr = 32'h0001_0010; mIf.writeAddr_valid = 1;
        mIf.writeData_data = {4{32'h1234_5678}}; mIf.writeData_strb = 16'hFFFF; mIf.writeData_valid = 1;
        step(); // IDLE -> REQ
        checks++; if (s2If.writeAddr_valid !== 1'b1) begin errors++; $display("FAIL wr2_awvalid got %b exp 1", s2If.writeAddr_valid); end
        checks++; if (s2If.writeAddr_addr !== 32'h0001_0010) begin errors++; $display("FAIL wr2_awaddr got %h exp 00010010", s2If.writeAddr_addr); end
        checks++; if (s2If.writeData_data !== {4{32'h1234_5678}}) begin errors++; $display("FAIL wr2_wdata got %h exp 12345678..", s2If.writeData_data); end
        checks++; if (s2If.writeData_strb !== 16'hFFFF) begin errors++; $display("FAIL wr2_wstrb got %h exp ffff", s2If.writeData_strb); end
        checks++; if (s1If.writeAddr_valid !== 1'b0) begin errors++; $display("FAIL wr2_s1awvalid got %b exp 0", s1If.writeAddr_valid); end
        checks++; if (s1If.writeData_data !== 128'h0) begin errors++; $display("FAIL wr2_s1wdata got %h exp 0", s1If.writeData_data); end
        s2If.writeAddr_ready = 1; #1;
        checks++; if (mIf.writeAddr_ready !== 1'b0) begin errors++; $display("FAIL wr2_joint_ready got %b exp 0", mIf.writeAddr_ready); end
        s2If.writeData_ready = 1; #1;
        checks++; if (mIf.writeData_ready !== 1'b1) begin errors++; $display("FAIL wr2_wready got %b exp 1", mIf.writeData_ready); end
        step(); // REQ -> RESP
        mIf.writeAddr_valid = 0; mIf.writeData_valid = 0;
        s2If.writeAddr_ready = 0; s2If.writeData_ready = 0;
        s2If.writeResp_msg = 32'h0; s2If.writeResp_valid = 1; mIf.writeResp_ready = 1; #1;
        checks++; if (mIf.writeResp_valid !== 1'b1) begin errors++; $display("FAIL wr2_bvalid got %b exp 1", mIf.writeResp_valid); end
        checks++; if (mIf.writeResp_msg !== 32'h0) begin errors++; $display("FAIL wr2_msg got %h exp 0", mIf.writeResp_msg); end
        checks++; if (s2If.writeResp_ready !== 1'b1) begin errors++; $display("FAIL wr2_s2bready got %b exp 1", s2If.writeResp_ready); end
        step(); // RESP -> IDLE
        clear_inputs(); #1;
        checks++; if (writeState !== 2'd0) begin errors++; $display("FAIL wr2_done_state got %0d exp 0", writeState); end
        step();
    endtask

    task automatic test_decerr;
        mIf.readAddr_addr = 32'h8000_0000; mIf.readAddr_valid = 1;
        step(); // IDLE -> REQ
        checks++; if (mIf.readAddr_ready !== 1'b1) begin errors++; $display("FAIL de_arready got %b exp 1", mIf.readAddr_ready); end
        checks++; if (s1If.readAddr_valid !== 1'b0 || s2If.readAddr_valid !== 1'b0) begin errors++; $display("FAIL de_slave_arvalid got %b%b exp 00", s1If.readAddr_valid, s2If.readAddr_valid); end
        step(); // REQ -> RESP
        mIf.readAddr_valid = 0; mIf.readData_ready = 1; #1;
        checks++; if (mIf.readData_valid !== 1'b1) begin errors++; $display("FAIL de_rvalid got %b exp 1", mIf.readData_valid); end
        checks++; if (mIf.readData_data !== 128'h0) begin errors++; $display("FAIL de_rdata got %h exp 0", mIf.readData_data); end
        step(); // RESP -> IDLE
        clear_inputs(); #1;
        checks++; if (readState !== 2'd0) begin errors++; $display("FAIL de_rd_done got %0d exp 0", readState); end
        step();
        mIf.writeAddr_addr = 32'h8000_0000; mIf.writeAddr_valid = 1;
        mIf.writeData_data = {4{32'hFFFF_0000}}; mIf.writeData_strb = 16'h000F; mIf.writeData_valid = 1;
        step(); // IDLE -> REQ
        checks++; if (mIf.writeAddr_ready !== 1'b1 || mIf.writeData_ready !== 1'b1) begin errors++; $display("FAIL de_wr_readys got %b%b exp 11", mIf.writeAddr_ready, mIf.writeData_ready); end
        checks++; if (s1If.writeAddr_valid !== 1'b0 || s2If.writeAddr_valid !== 1'b0) begin errors++; $display("FAIL de_slave_awvalid got %b%b exp 00", s1If.writeAddr_valid, s2If.writeAddr_valid); end
        step(); // REQ -> RESP
        mIf.writeAddr_valid = 0; mIf.writeData_valid = 0; mIf.writeResp_ready = 1; #1;
        checks++; if (mIf.writeResp_valid !== 1'b1) begin errors++; $display("FAIL de_bvalid got %b exp 1", mIf.writeResp_valid); end
        checks++; if (mIf.writeResp_msg !== 32'h3) begin errors++; $display("FAIL de_msg got %h exp 3", mIf.writeResp_msg); end
        step(); // RESP -> IDLE
        clear_inputs(); #1;
        checks++; if (writeState !== 2'd0) begin errors++; $display("FAIL de_wr_done got %0d exp 0", writeState); end
        step();
    endtask

    task automatic test_concurrent;
        mIf.readAddr_addr = 32'h0000_0100; mIf.readAddr_valid = 1;
        mIf.writeAddr_addr = 32'h0001_0020; mIf.writeAddr_valid = 1;
        mIf.writeData_data = {4{32'hCAFE_F00D}}; mIf.writeData_strb = 16'h00F0; mIf.writeData_valid = 1;
        step(); // both IDLE -> REQ
        checks++; if (s1If.readAddr_valid !== 1'b1) begin errors++; $display("FAIL cc_s1arvalid got %b exp 1", s1If.readAddr_valid); end
        checks++; if (s2If.writeAddr_valid !== 1'b1) begin errors++; $display("FAIL cc_s2awvalid got %b exp 1", s2If.writeAddr_valid); end
        checks++; if (s2If.writeData_strb !== 16'h00F0) begin errors++; $display("FAIL cc_s2strb got %h exp 00f0", s2If.writeData_strb); end
        checks++; if (s2If.readAddr_valid !== 1'b0 || s1If.writeAddr_valid !== 1'b0) begin errors++; $display("FAIL cc_cross got %b%b exp 00", s2If.readAddr_valid, s1If.writeAddr_valid); end
        s1If.readAddr_ready = 1; s2If.writeAddr_ready = 1; s2If.writeData_ready = 1;
        step(); // both REQ -> RESP
        mIf.readAddr_valid = 0; mIf.writeAddr_valid = 0; mIf.writeData_valid = 0;
        s1If.readAddr_ready = 0; s2If.writeAddr_ready = 0; s2If.writeData_ready = 0;
        s1If.readData_data = {4{32'h7777_0001}}; s1If.readData_valid = 1;
        s2If.writeResp_msg = 32'h0000_0001; s2If.writeResp_valid = 1;
        mIf.readData_ready = 1; mIf.writeResp_ready = 1; #1;
        checks++; if (mIf.readData_data !== {4{32'h7777_0001}}) begin errors++; $display("FAIL cc_rdata got %h exp 77770001..", mIf.readData_data); end
        checks++; if (mIf.writeResp_msg !== 32'h0000_0001) begin errors++; $display("FAIL cc_msg got %h exp 1", mIf.writeResp_msg); end
        step(); // both RESP -> IDLE
        clear_inputs(); #1;
        checks++; if (readState !== 2'd0 || writeState !== 2'd0) begin errors++; $display("FAIL cc_done got %0d/%0d exp 0/0", readState, writeState); end
        step();
    endtask

    task automatic test_backpressure;
        mIf.readAddr_addr = 32'h0000_0200; mIf.readAddr_valid = 1;
        step(); // IDLE -> REQ
        s1If.readAddr_ready = 1;
        step(); // REQ -> RESP
        mIf.readAddr_valid = 0; s1If.readAddr_ready = 0;
        s1If.readData_data = {4{32'h5555_AAAA}}; s1If.readData_valid = 1; mIf.readData_ready = 0;
        repeat (5) begin
            #1;
            checks++; if (s1If.readData_ready !== 1'b0) begin errors++; $display("FAIL bp_s1rready got %b exp 0", s1If.readData_ready); end
            checks++; if (readState !== 2'd2) begin errors++; $display("FAIL bp_state got %0d exp 2", readState); end
            step();
        end
        mIf.readData_ready = 1; #1;
        checks++; if (s1If.readData_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", s1If.readData_ready); end
        step(); // RESP -> IDLE
        clear_inputs(); #1;
        checks++; if (readState !== 2'd0) begin errors++; $display("FAIL bp_done got %0d exp 0", readState); end
        step();
    endtask

    task automatic test_reset_mid;
        mIf.writeAddr_addr = 32'h0000_0008; mIf.writeAddr_valid = 1;
        mIf.writeData_data = {4{32'h0BAD_0BAD}}; mIf.writeData_strb = 16'h0001; mIf.writeData_valid = 1;
        step(); // IDLE -> REQ
        s1If.writeAddr_ready = 1; s1If.writeData_ready = 1;
        step(); // REQ -> RESP
        mIf.writeAddr_valid = 0; mIf.writeData_valid = 0;
        s1If.writeAddr_ready = 0; s1If.writeData_ready = 0;
        s1If.writeResp_msg = 32'h0000_0055; s1If.writeResp_valid = 1; #1;
        checks++; if (mIf.writeResp_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_bvalid got %b exp 1", mIf.writeResp_valid); end
        rst = 1'b1; #1;
        checks++; if (mIf.writeResp_valid !== 1'b0) begin errors++; $display("FAIL rm_bvalid got %b exp 0", mIf.writeResp_valid); end
        checks++; if (mIf.writeResp_msg !== 32'h0) begin errors++; $display("FAIL rm_msg got %h exp 0", mIf.writeResp_msg); end
        checks++; if (writeState !== 2'd0) begin errors++; $display("FAIL rm_state got %0d exp 0", writeState); end
        step();
        clear_inputs();
        rst = 1'b0;
        step();
        mIf.readAddr_addr = 32'h0001_0000; mIf.readAddr_valid = 1;
        step(); // IDLE -> REQ
        checks++; if (s2If.readAddr_valid !== 1'b1 || s1If.readAddr_valid !== 1'b0) begin errors++; $display("FAIL rm_post_route got %b%b exp 10", s2If.readAddr_valid, s1If.readAddr_valid); end
        s2If.readAddr_ready = 1;
        step(); // REQ -> RESP
        mIf.readAddr_valid = 0; s2If.readAddr_ready = 0;
        s2If.readData_data = {4{32'hDEAD_BEEF}}; s2If.readData_valid = 1; mIf.readData_ready = 1; #1;
        checks++; if (mIf.readData_data !== {4{32'hDEAD_BEEF}}) begin errors++; $display("FAIL rm_post_rdata got %h exp deadbeef..", mIf.readData_data); end
        step(); // RESP -> IDLE
        clear_inputs(); #1;
        checks++; if (readState !== 2'd0) begin errors++; $display("FAIL rm_post_done got %0d exp 0", readState); end
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        test_reset();
        test_read_s1();
        test_write_s2();
        test_decerr();
        test_concurrent();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
